// File: rtl/mips_mem_arbiter_if.sv
// Bundle of every handshake and bus signal around mips_mem_arbiter.
//   inst_*  : instruction-fetch request/response channel
//   data_*  : data-access request/response channel (reads and writes)
//   mem_*   : single downstream memory port (request + response)
// Modports:
//   slave   : the arbiter's view (it serves the requesters and drives memory)
//   master  : the surrounding system's view (requesters + memory model)
interface mips_mem_arbiter_if;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_addr;
  logic        inst_resp_valid;
  logic        inst_resp_ready;
  logic [31:0] inst_rdata;

  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_addr;
  logic        data_wen;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_resp_valid;
  logic        data_resp_ready;
  logic [31:0] data_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req_valid, inst_addr, inst_resp_ready,
    input  data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output inst_req_ready, inst_resp_valid, inst_rdata,
    output data_req_ready, data_resp_valid, data_rdata,
    output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb, mem_resp_ready
  );

  modport master (
    output inst_req_valid, inst_addr, inst_resp_ready,
    output data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  inst_req_ready, inst_resp_valid, inst_rdata,
    input  data_req_ready, data_resp_valid, data_rdata,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb, mem_resp_ready
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of one memory port.
// One transaction in flight at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Simultaneous requests alternate round-robin; a saturating watchdog raises a
// sticky timeout_err when the memory response is TIMEOUT cycles late.
// Ports:
//   mips_cpu_clk     : clock, rising edge
//   mips_cpu_reset_n : synchronous active-low reset
//   bus              : mips_mem_arbiter_if.slave (requester + memory channels)
//   timeout_err      : sticky watchdog flag, cleared only by reset
module mips_mem_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic                  mips_cpu_clk,
  input  logic                  mips_cpu_reset_n,
  mips_mem_arbiter_if.slave     bus,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t            state_q;
  owner_t            owner_q;
  owner_t            last_grant_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              wen_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       inst_rdata_q;
  logic [31:0]       data_rdata_q;
  logic              mem_req_valid_q;
  logic              mem_resp_ready_q;
  logic              inst_resp_valid_q;
  logic              data_resp_valid_q;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic              timeout_err_q;

  logic idle;
  logic gnt_inst;
  logic gnt_data;

  // Readys are combinational in IDLE but forced low while reset is asserted.
  assign idle     = (state_q == S_IDLE) && mips_cpu_reset_n;
  // Data wins when alone, or on a tie when fetch was served last.
  assign gnt_data = idle && bus.data_req_valid &&
                    (!bus.inst_req_valid || (last_grant_q == OWN_INST));
  assign gnt_inst = idle && bus.inst_req_valid && !gnt_data;

  assign bus.inst_req_ready  = gnt_inst;
  assign bus.data_req_ready  = gnt_data;
  assign bus.mem_req_valid   = mem_req_valid_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_wen         = wen_q;
  assign bus.mem_wstrb       = wstrb_q;
  assign bus.mem_resp_ready  = mem_resp_ready_q;
  assign bus.inst_resp_valid = inst_resp_valid_q;
  assign bus.inst_rdata      = inst_rdata_q;
  assign bus.data_resp_valid = data_resp_valid_q;
  assign bus.data_rdata      = data_rdata_q;
  assign timeout_err         = timeout_err_q;

  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_reset_n) begin
      state_q           <= S_IDLE;
      owner_q           <= OWN_INST;
      last_grant_q      <= OWN_INST;
      addr_q            <= '0;
      wdata_q           <= '0;
      wen_q             <= 1'b0;
      wstrb_q           <= '0;
      inst_rdata_q      <= '0;
      data_rdata_q      <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_resp_ready_q  <= 1'b0;
      inst_resp_valid_q <= 1'b0;
      data_resp_valid_q <= 1'b0;
      wd_cnt_q          <= '0;
      timeout_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_data) begin
            owner_q         <= OWN_DATA;
            last_grant_q    <= OWN_DATA;
            addr_q          <= bus.data_addr;
            wen_q           <= bus.data_wen;
            wdata_q         <= bus.data_wdata;
            wstrb_q         <= bus.data_wstrb;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end else if (gnt_inst) begin
            // Fetches are reads: write-side fields are driven to zero.
            owner_q         <= OWN_INST;
            last_grant_q    <= OWN_INST;
            addr_q          <= bus.inst_addr;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            wd_cnt_q         <= '0;
            state_q          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            mem_resp_ready_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              // Writes still get a response, but never carry read data.
              data_rdata_q      <= wen_q ? '0 : bus.mem_rdata;
              data_resp_valid_q <= 1'b1;
            end else begin
              inst_rdata_q      <= bus.mem_rdata;
              inst_resp_valid_q <= 1'b1;
            end
            state_q <= S_RESP;
          end else begin
            // Saturating count; the flag rises on the edge the count hits TIMEOUT
            // and the transaction keeps waiting.
            if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_cnt_q == WD_MAX - 1'b1) timeout_err_q <= 1'b1;
          end
        end
        S_RESP: begin
          if ((owner_q == OWN_DATA) ? bus.data_resp_ready : bus.inst_resp_ready) begin
            inst_resp_valid_q <= 1'b0;
            data_resp_valid_q <= 1'b0;
            state_q           <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter. Agents drive inputs 1ns after the
// rising edge and sample on the falling edge; expected memory requests and
// requester responses are queued when stimulus is issued.
module tb_mips_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_err;

  always #5 clk = ~clk;

  mips_mem_arbiter_if bus ();

  mips_mem_arbiter #(.TIMEOUT(TO)) dut (
    .mips_cpu_clk     (clk),
    .mips_cpu_reset_n (rst_n),
    .bus              (bus),
    .timeout_err      (timeout_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        owner;   // 1 = data, 0 = inst
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] inst_src[$];
  req_t        data_src[$];
  req_t        mem_exp[$];
  resp_t       resp_exp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_issued = 0;
  int mem_hs_cnt = 0;
  int req_stall = 0;
  int resp_delay = 0;
  int inst_rr_stall = 0;
  int data_rr_stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h6408_0001;
  endfunction

  task automatic send_inst(input logic [31:0] a);
    inst_src.push_back(a);
    mem_exp.push_back({a, 1'b0, 32'h0, 4'h0});
    resp_exp.push_back({1'b0, mem_word(a)});
    n_issued++;
  endtask

  task automatic send_data(input logic [31:0] a, input logic wen,
                           input logic [31:0] wd, input logic [3:0] ws);
    data_src.push_back({a, wen, wd, ws});
    mem_exp.push_back({a, wen, wd, ws});
    resp_exp.push_back({1'b1, wen ? 32'h0 : mem_word(a)});
    n_issued++;
  endtask

  // instruction-fetch requester
  initial begin
    logic hs;
    bus.inst_req_valid = 1'b0;
    bus.inst_addr      = 32'h0;
    forever begin
      @(negedge clk);
      hs = bus.inst_req_valid && bus.inst_req_ready;
      @(posedge clk); #1;
      if (hs) void'(inst_src.pop_front());
      if (inst_src.size() > 0) begin
        bus.inst_req_valid = 1'b1;
        bus.inst_addr      = inst_src[0];
      end else begin
        bus.inst_req_valid = 1'b0;
        bus.inst_addr      = 32'h0;
      end
    end
  end

  // data requester
  initial begin
    logic hs;
    bus.data_req_valid = 1'b0;
    bus.data_addr      = 32'h0;
    bus.data_wen       = 1'b0;
    bus.data_wdata     = 32'h0;
    bus.data_wstrb     = 4'h0;
    forever begin
      @(negedge clk);
      hs = bus.data_req_valid && bus.data_req_ready;
      @(posedge clk); #1;
      if (hs) void'(data_src.pop_front());
      if (data_src.size() > 0) begin
        bus.data_req_valid = 1'b1;
        bus.data_addr      = data_src[0].addr;
        bus.data_wen       = data_src[0].wen;
        bus.data_wdata     = data_src[0].wdata;
        bus.data_wstrb     = data_src[0].wstrb;
      end else begin
        bus.data_req_valid = 1'b0;
      end
    end
  end

  // memory model: configurable request stall and response delay
  initial begin
    logic        pending;
    logic [31:0] paddr;
    int          stall_cnt;
    int          wait_cnt;
    logic        rq_hs;
    logic        rs_hs;
    req_t        e;
    pending = 1'b0;
    paddr = 32'h0;
    stall_cnt = 0;
    wait_cnt = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      rq_hs = bus.mem_req_valid && bus.mem_req_ready;
      rs_hs = bus.mem_resp_valid && bus.mem_resp_ready;
      if (rq_hs) begin
        mem_hs_cnt++;
        check_eq("mem_req_expected", 32'(mem_exp.size() != 0), 32'd1);
        if (mem_exp.size() != 0) begin
          e = mem_exp.pop_front();
          check_eq("mem_addr", bus.mem_addr, e.addr);
          check_eq("mem_wen", 32'(bus.mem_wen), 32'(e.wen));
          check_eq("mem_wdata", bus.mem_wdata, e.wdata);
          check_eq("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
        end
        pending   = 1'b1;
        paddr     = bus.mem_addr;
        wait_cnt  = 0;
        stall_cnt = 0;
      end else if (bus.mem_req_valid && !bus.mem_req_ready) begin
        stall_cnt++;
      end
      if (rs_hs) pending = 1'b0;
      else if (pending && bus.mem_resp_ready) wait_cnt++;
      @(posedge clk); #1;
      bus.mem_req_ready  = (stall_cnt >= req_stall);
      bus.mem_resp_valid = pending && (wait_cnt >= resp_delay);
      bus.mem_rdata      = bus.mem_resp_valid ? mem_word(paddr) : 32'hDEAD_BEEF;
    end
  end

  // response consumer: pops the scoreboard on each response handshake
  initial begin
    int    is_cnt;
    int    ds_cnt;
    logic  ihs;
    logic  dhs;
    resp_t e;
    is_cnt = 0;
    ds_cnt = 0;
    bus.inst_resp_ready = 1'b0;
    bus.data_resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      ihs = bus.inst_resp_valid && bus.inst_resp_ready;
      dhs = bus.data_resp_valid && bus.data_resp_ready;
      if (bus.inst_resp_valid || bus.data_resp_valid)
        check_eq("resp_exclusive", 32'(bus.inst_resp_valid && bus.data_resp_valid), 32'd0);
      if (ihs || dhs) begin
        check_eq("resp_expected", 32'(resp_exp.size() != 0), 32'd1);
        if (resp_exp.size() != 0) begin
          e = resp_exp.pop_front();
          check_eq("resp_owner", 32'(dhs), 32'(e.owner));
          check_eq("resp_rdata", dhs ? bus.data_rdata : bus.inst_rdata, e.rdata);
        end
      end
      if (ihs) is_cnt = 0;
      else if (bus.inst_resp_valid) is_cnt++;
      if (dhs) ds_cnt = 0;
      else if (bus.data_resp_valid) ds_cnt++;
      @(posedge clk); #1;
      bus.inst_resp_ready = (is_cnt >= inst_rr_stall);
      bus.data_resp_ready = (ds_cnt >= data_rr_stall);
    end
  end

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_exp.size() == 0 && resp_exp.size() == 0 && inst_src.size() == 0 &&
          data_src.size() == 0 && !bus.inst_resp_valid && !bus.data_resp_valid &&
          !bus.mem_req_valid && !bus.mem_resp_ready) break;
    end
    check_eq(tag, 32'(i < 300), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int which);
    int   i;
    logic hit;
    hit = 1'b0;
    for (i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = bus.inst_req_valid && bus.inst_req_ready;
        1: hit = bus.mem_req_valid;
        2: hit = bus.data_resp_valid;
        default: hit = bus.mem_resp_ready;
      endcase
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int base_hs;
    rst_n = 1'b0;

    // Reset with both requesters valid; these four requests then contend.
    send_data(32'h4000_0100, 1'b0, 32'h0, 4'h0);
    send_inst(32'h4000_0200);
    send_data(32'h4000_0104, 1'b1, 32'hCAFE_F00D, 4'h3);
    send_inst(32'h4000_0204);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("reset_quiet",
               {25'h0, bus.inst_req_ready, bus.data_req_ready, bus.mem_req_valid,
                bus.mem_resp_ready, bus.inst_resp_valid, bus.data_resp_valid, timeout_err},
               32'h0);
      check_eq("reset_mem_addr", bus.mem_addr, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_grant", {30'h0, bus.inst_req_ready, bus.data_req_ready}, 32'h1);
    drain("contention_drain");

    // Single fetch with minimum latency.
    send_inst(32'h4000_0000);
    wait_for("fetch_handshake", 0);
    @(negedge clk);
    check_eq("fetch_T1_req_valid", 32'(bus.mem_req_valid), 32'd1);
    check_eq("fetch_T1_addr", bus.mem_addr, 32'h4000_0000);
    check_eq("fetch_T1_wen", 32'(bus.mem_wen), 32'd0);
    @(negedge clk);
    check_eq("fetch_T2_resp_ready", 32'(bus.mem_resp_ready), 32'd1);
    @(negedge clk);
    check_eq("fetch_T3_resp_valid", 32'(bus.inst_resp_valid), 32'd1);
    check_eq("fetch_T3_rdata", bus.inst_rdata, 32'h2408_0001);
    @(negedge clk);
    check_eq("fetch_T4_idle", {30'h0, bus.inst_resp_valid, bus.mem_req_valid}, 32'h0);
    drain("fetch_drain");

    // Data write.
    send_data(32'h4000_000C, 1'b1, 32'h0, 4'hF);
    wait_for("write_req", 1);
    check_eq("write_wen", 32'(bus.mem_wen), 32'd1);
    check_eq("write_wstrb", 32'(bus.mem_wstrb), 32'hF);
    wait_for("write_resp", 2);
    check_eq("write_rdata", bus.data_rdata, 32'h0);
    drain("write_drain");

    // Backpressure on the memory request, then on the data response.
    base_hs = mem_hs_cnt;
    req_stall = 5;
    data_rr_stall = 3;
    send_data(32'h4000_0040, 1'b0, 32'h0, 4'h0);
    wait_for("bp_req", 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("bp_req_held", 32'(bus.mem_req_valid), 32'd1);
      check_eq("bp_addr_stable", bus.mem_addr, 32'h4000_0040);
    end
    wait_for("bp_resp", 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("bp_resp_held", 32'(bus.data_resp_valid), 32'd1);
      check_eq("bp_rdata_stable", bus.data_rdata, mem_word(32'h4000_0040));
      check_eq("bp_no_new_req", 32'(bus.mem_req_valid), 32'd0);
    end
    drain("bp_drain");
    check_eq("bp_single_mem_req", 32'(mem_hs_cnt - base_hs), 32'd1);
    req_stall = 0;
    data_rr_stall = 0;

    // Watchdog: memory holds off for 20 WAIT cycles.
    resp_delay = 20;
    send_inst(32'h4000_0300);
    wait_for("wd_wait", 3);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check_eq($sformatf("wd_flag_k%0d", k), 32'(timeout_err), 32'(k >= TO));
    end
    drain("wd_drain");
    check_eq("wd_sticky_idle", 32'(timeout_err), 32'd1);
    resp_delay = 0;
    send_inst(32'h4000_0304);
    drain("wd_next_drain");
    check_eq("wd_sticky_next", 32'(timeout_err), 32'd1);

    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("wd_cleared_by_reset", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("total_mem_reqs", 32'(mem_hs_cnt), 32'(n_issued));
    check_eq("scoreboard_empty", 32'(mem_exp.size() + resp_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-requester memory arbiter between the MIPS CPU's instruction-fetch and data-access units and the single memory port that reaches the AXI-mapped memory at 0x4000_0000. It runs one transaction at a time: request latch, memory request, memory response, requester response. Simultaneous requests are granted round-robin. A saturating watchdog flags a memory response that fails to arrive in time.

## Interface
- TIMEOUT, 1024: cycles in WAIT before `timeout_err` is set; must be ≥ 2.
- mips_cpu_clk  in  1  sole clock; all state changes on the rising edge.
- mips_cpu_reset_n  in  1  synchronous, active-low reset.
- inst_req_valid / inst_req_ready  in / out  1  fetch request handshake.
- inst_addr  in  32  fetch word address.
- inst_resp_valid / inst_resp_ready  out / in  1  fetch response handshake.
- inst_rdata  out  32  fetched word.
- data_req_valid / data_req_ready  in / out  1  data request handshake.
- data_addr  in  32  data address.
- data_wen  in  1  1 = write, 0 = read.
- data_wdata  in  32  write data.
- data_wstrb  in  4  byte strobes.
- data_resp_valid / data_resp_ready  out / in  1  data response handshake; writes also receive a response.
- data_rdata  out  32  read data; 0 for writes.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_addr, mem_wdata  out  32  latched request fields.
- mem_wen  out  1  latched write flag.
- mem_wstrb  out  4  latched strobes.
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake.
- mem_rdata  in  32  memory read data.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE → REQ → WAIT → RESP → IDLE.
- **IDLE**
  - Grant goes to the only valid requester.
  - If both requesters are valid, grant goes to the one not served last. `last_grant` resets to inst, so the first tie goes to data.
  - The granted port's `*_req_ready` is 1 combinationally in IDLE.
  - On handshake: latch addr, wen, wdata, wstrb, and owner; update `last_grant`; go to REQ.
  - For an inst grant, latch wen = 0, wstrb = 0, wdata = 0.
- **REQ**
  - `mem_req_valid` = 1 with the latched fields.
  - On `mem_req_ready` go to WAIT and clear the watchdog counter.
- **WAIT**
  - `mem_resp_ready` = 1.
  - On `mem_resp_valid`: latch `mem_rdata` (force 0 for writes) and go to RESP.
  - Otherwise increment the counter, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, `timeout_err` := 1. It is sticky until reset. WAIT continues; no transaction is aborted.
- **RESP**
  - The owner's `*_resp_valid` = 1 and its rdata holds the latched value.
  - On the owner's `*_resp_ready` go to IDLE.
  - The non-owner's resp_valid is always 0.
- Requester rules:
  - Requesters hold request fields stable until ready.
  - A requester deasserting valid before its handshake is permitted. It is simply not granted.
- Requests arriving outside IDLE wait; their ready stays 0.

## Timing
- Reset values:
  - state IDLE, `last_grant` = inst, counter 0, `timeout_err` 0.
  - All `*_valid` and `*_ready` outputs 0 except the combinational IDLE grant readys.
  - inst_rdata, data_rdata, and all mem_* fields 0.
- Reset mid-transaction:
  - Returns to IDLE the next edge and drops all valids.
  - Any pending memory response is not accepted: `mem_resp_ready` is 0 outside WAIT.
- Minimum latency, with mem ready and response immediate and resp_ready held 1:
  - request handshake at cycle T
  - `mem_req_valid` at T+1
  - `mem_resp_valid` accepted at T+2 at earliest
  - `*_resp_valid` at T+3
  - back in IDLE at T+4
- Back-to-back throughput: one transaction per 4 cycles minimum.
- Watchdog: `timeout_err` rises on the edge on which the counter, incremented each non-response cycle in WAIT, reaches TIMEOUT.

## Test plan
- **Reset:** hold reset_n = 0 for 4 cycles with both requests valid → all readys, valids, and `timeout_err` stay 0; the first grant after release goes to data.
- **Single fetch:** inst_addr = 0x4000_0000, mem_rdata = 0x2408_0001 → `mem_addr` = 0x4000_0000 with `mem_wen` = 0; `inst_resp_valid` at T+3 with `inst_rdata` = 0x2408_0001.
- **Data write:** data_addr = 0x4000_000C, wdata = 0, wstrb = 0xF → mem sees wen = 1 and wstrb = 0xF; `data_resp_valid` with `data_rdata` = 0.
- **Contention:** both requesters valid continuously for 4 transactions → grant order data, inst, data, inst; each response goes only to its owner.
- **Backpressure:** `mem_req_ready` low for 5 cycles, then `data_resp_ready` low for 3 cycles → fields stay stable and valids stay held; no extra memory request is issued.
- **Watchdog:** TIMEOUT = 8, memory never responds → `timeout_err` = 1 after 8 WAIT cycles; a response at cycle 20 still completes; the flag stays 1 until reset.
